// File: rtl/vinput_frame_collector_pkg.sv
// Shared constants, width helper and frame vector type for the vinput frame collector.
package vinput_pkg;

  localparam int N_DEFAULT         = 14;
  localparam int DATAWIDTH_DEFAULT = 32;

  // Index fields must hold the value N itself, hence the extra bit.
  function automatic int clog2_plus1(input int n);
    return $clog2(n) + 1;
  endfunction

  typedef logic [N_DEFAULT-1:0][DATAWIDTH_DEFAULT-1:0] frame_t;

endpackage

// File: rtl/vinput_frame_collector_stat_acc.sv
// Running signed sum and running argmax over the samples of the frame being filled.
module frame_stat_acc
  import vinput_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEFAULT,
  parameter int SUM_WIDTH = DATAWIDTH_DEFAULT + $clog2(N_DEFAULT) + 1,
  parameter int IDX_WIDTH = clog2_plus1(N_DEFAULT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 accept_i,
  input  logic                 restart_i,
  input  logic [IDX_WIDTH-1:0] idx_i,
  input  logic [DATAWIDTH-1:0] sample_i,
  output logic [SUM_WIDTH-1:0] sum_o,
  output logic [IDX_WIDTH-1:0] max_idx_o
);

  logic [SUM_WIDTH-1:0] sum_q, sum_d;
  logic [DATAWIDTH-1:0] max_q, max_d;
  logic [IDX_WIDTH-1:0] max_idx_q, max_idx_d;
  logic [SUM_WIDTH-1:0] sample_ext;

  assign sample_ext = {{(SUM_WIDTH-DATAWIDTH){sample_i[DATAWIDTH-1]}}, sample_i};

  // start_i makes this sample the first of a frame regardless of the held state;
  // a strict greater-than keeps the lowest index on ties.
  always_comb begin
    sum_d     = sum_q;
    max_d     = max_q;
    max_idx_d = max_idx_q;
    if (accept_i) begin
      sum_d = (start_i ? '0 : sum_q) + sample_ext;
      if (start_i || ($signed(sample_i) > $signed(max_q))) begin
        max_d     = sample_i;
        max_idx_d = idx_i;
      end
    end
  end

  // The outputs include the current sample so the top can capture a completed frame.
  assign sum_o     = sum_d;
  assign max_idx_o = max_idx_d;

  always_ff @(posedge clk) begin
    if (rst || restart_i) begin
      sum_q     <= '0;
      max_q     <= '0;
      max_idx_q <= '0;
    end else begin
      sum_q     <= sum_d;
      max_q     <= max_d;
      max_idx_q <= max_idx_d;
    end
  end

endmodule

// File: rtl/vinput_frame_collector.sv
// Collects N vinput samples per frame into ping-pong banks and hands frames downstream.
module vinput_frame_collector
  import vinput_pkg::*;
#(
  parameter int N         = N_DEFAULT,
  parameter int DATAWIDTH = DATAWIDTH_DEFAULT,
  parameter int SUM_WIDTH = DATAWIDTH + $clog2(N) + 1,
  parameter int IDX_WIDTH = clog2_plus1(N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATAWIDTH-1:0]   vinput,
  input  logic                   vinput_tvalid,
  input  logic                   frame_restart,
  input  logic                   clear_err,
  output logic [N*DATAWIDTH-1:0] frame_out,
  output logic [SUM_WIDTH-1:0]   sum_out,
  output logic [IDX_WIDTH-1:0]   max_idx,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDX_WIDTH-1:0]   fill_level,
  output logic                   overflow
);

  logic [DATAWIDTH-1:0] bank_q [2][N];
  logic [SUM_WIDTH-1:0] bank_sum_q [2];
  logic [IDX_WIDTH-1:0] bank_idx_q [2];
  logic [1:0]           full_q;
  logic                 wb_q, rb_q;
  logic [IDX_WIDTH-1:0] cnt_q, cnt_d;
  logic                 overflow_q;

  logic                 release_w, accept_w, drop_w, complete_w;
  logic                 acc_start, acc_restart;
  logic [IDX_WIDTH-1:0] wr_idx;
  logic [SUM_WIDTH-1:0] acc_sum;
  logic [IDX_WIDTH-1:0] acc_idx;

  // Downstream handshake: out_valid stays high with frame_out/sum_out/max_idx frozen
  // until out_ready is seen high on a clock edge; that edge frees the read bank.
  assign release_w = full_q[rb_q] && out_ready;

  // Upstream cannot stall, so a sample is dropped only when its bank is still
  // occupied and not being freed in this same cycle.
  assign accept_w   = vinput_tvalid && (!full_q[wb_q] || (release_w && (rb_q == wb_q)));
  assign drop_w     = vinput_tvalid && !accept_w;
  assign complete_w = accept_w && !frame_restart && (cnt_q == IDX_WIDTH'(N-1));

  assign acc_start   = frame_restart || (cnt_q == '0);
  assign wr_idx      = frame_restart ? '0 : cnt_q;
  assign acc_restart = complete_w || (frame_restart && !accept_w);

  always_comb begin
    cnt_d = cnt_q;
    if (frame_restart) begin
      cnt_d = accept_w ? IDX_WIDTH'(1) : '0;
    end else if (accept_w) begin
      cnt_d = complete_w ? '0 : cnt_q + IDX_WIDTH'(1);
    end
  end

  frame_stat_acc #(
    .DATAWIDTH (DATAWIDTH),
    .SUM_WIDTH (SUM_WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_stat_acc (
    .clk       (clk),
    .rst       (rst),
    .start_i   (acc_start),
    .accept_i  (accept_w),
    .restart_i (acc_restart),
    .idx_i     (wr_idx),
    .sample_i  (vinput),
    .sum_o     (acc_sum),
    .max_idx_o (acc_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < N; k++) begin
          bank_q[b][k] <= '0;
        end
        bank_sum_q[b] <= '0;
        bank_idx_q[b] <= '0;
      end
      full_q     <= '0;
      wb_q       <= 1'b0;
      rb_q       <= 1'b0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (accept_w) begin
        for (int k = 0; k < N; k++) begin
          if (wr_idx == IDX_WIDTH'(k)) begin
            bank_q[wb_q][k] <= vinput;
          end
        end
      end
      cnt_q <= cnt_d;
      if (release_w) begin
        full_q[rb_q] <= 1'b0;
        rb_q         <= ~rb_q;
      end
      // Completion is applied after release so a freed-and-refilled bank ends up full.
      if (complete_w) begin
        full_q[wb_q]     <= 1'b1;
        wb_q             <= ~wb_q;
        bank_sum_q[wb_q] <= acc_sum;
        bank_idx_q[wb_q] <= acc_idx;
      end
      if (drop_w) begin
        overflow_q <= 1'b1;
      end else if (clear_err) begin
        overflow_q <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_frame_out
    assign frame_out[k*DATAWIDTH +: DATAWIDTH] = bank_q[rb_q][k];
  end

  assign out_valid  = full_q[rb_q];
  assign sum_out    = bank_sum_q[rb_q];
  assign max_idx    = bank_idx_q[rb_q];
  assign fill_level = cnt_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_vinput_frame_collector.sv
// Directed and randomized checks of the frame collector against a queue-based reference model.
module tb_vinput_frame_collector;
  import vinput_pkg::*;

  localparam int N  = N_DEFAULT;
  localparam int DW = DATAWIDTH_DEFAULT;
  localparam int SW = DW + $clog2(N) + 1;
  localparam int IW = clog2_plus1(N);

  logic            clk;
  logic            rst;
  logic [DW-1:0]   vinput;
  logic            vinput_tvalid;
  logic            frame_restart;
  logic            clear_err;
  logic [N*DW-1:0] frame_out;
  logic [SW-1:0]   sum_out;
  logic [IW-1:0]   max_idx;
  logic            out_valid;
  logic            out_ready;
  logic [IW-1:0]   fill_level;
  logic            overflow;

  int total = 0;
  int bad   = 0;

  // Reference model: completed frames awaiting delivery, the partial frame, the error flag.
  logic [N*DW-1:0] exp_q[$];
  logic [DW-1:0]   part_q[$];
  logic            exp_ovf;

  vinput_frame_collector dut (
    .clk           (clk),
    .rst           (rst),
    .vinput        (vinput),
    .vinput_tvalid (vinput_tvalid),
    .frame_restart (frame_restart),
    .clear_err     (clear_err),
    .frame_out     (frame_out),
    .sum_out       (sum_out),
    .max_idx       (max_idx),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .fill_level    (fill_level),
    .overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [SW-1:0] ref_sum(input logic [N*DW-1:0] f);
    longint s = 0;
    for (int k = 0; k < N; k++) s += longint'($signed(f[k*DW +: DW]));
    return s[SW-1:0];
  endfunction

  function automatic logic [IW-1:0] ref_argmax(input logic [N*DW-1:0] f);
    int best = 0;
    for (int k = 1; k < N; k++)
      if ($signed(f[k*DW +: DW]) > $signed(f[best*DW +: DW])) best = k;
    return IW'(best);
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, settle 1 time unit after it.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic rdy,
                      input logic rs, input logic rst_in, input logic clr);
    logic            was_full;
    logic [N*DW-1:0] f;
    vinput_tvalid = v;
    vinput        = d;
    out_ready     = rdy;
    frame_restart = rs;
    rst           = rst_in;
    clear_err     = clr;
    @(posedge clk);
    if (rst_in) begin
      exp_q.delete();
      part_q.delete();
      exp_ovf = 1'b0;
    end else begin
      was_full = (exp_q.size() == 2);
      if (exp_q.size() > 0 && rdy) void'(exp_q.pop_front());
      if (rs) part_q.delete();
      if (v && was_full && !rdy) begin
        exp_ovf = 1'b1;
      end else begin
        if (clr) exp_ovf = 1'b0;
        if (v) begin
          part_q.push_back(d);
          if (part_q.size() == N) begin
            for (int k = 0; k < N; k++) f[k*DW +: DW] = part_q[k];
            exp_q.push_back(f);
            part_q.delete();
          end
        end
      end
    end
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic rdy);
    step(1'b1, d, rdy, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, '0, rdy, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    do_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    total++; if (sum_out !== '0) begin bad++; $display("FAIL reset_sum got=%0h exp=0", sum_out); end
    total++; if (max_idx !== '0) begin bad++; $display("FAIL reset_max_idx got=%0d exp=0", max_idx); end
    total++; if (frame_out !== '0) begin bad++; $display("FAIL reset_frame got=%0h exp=0", frame_out); end
    total++; if (fill_level !== '0) begin bad++; $display("FAIL reset_fill got=%0d exp=0", fill_level); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
  endtask

  task automatic test_basic();
    do_reset();
    for (int k = 1; k <= 13; k++) send(DW'(k), 1'b1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%0b exp=0", out_valid); end
    total++; if (fill_level !== IW'(13)) begin bad++; $display("FAIL basic_fill got=%0d exp=13", fill_level); end
    send(DW'(14), 1'b1);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0b exp=1", out_valid); end
    total++; if (sum_out !== SW'(105)) begin bad++; $display("FAIL basic_sum got=%0d exp=105", sum_out); end
    total++; if (max_idx !== IW'(13)) begin bad++; $display("FAIL basic_max_idx got=%0d exp=13", max_idx); end
    total++; if (frame_out[0 +: DW] !== DW'(1)) begin bad++; $display("FAIL basic_frame0 got=%0d exp=1", frame_out[0 +: DW]); end
    total++; if (frame_out[13*DW +: DW] !== DW'(14)) begin bad++; $display("FAIL basic_frame13 got=%0d exp=14", frame_out[13*DW +: DW]); end
    total++; if (fill_level !== '0) begin bad++; $display("FAIL basic_fill_after got=%0d exp=0", fill_level); end
    idle(1'b1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_consumed got=%0b exp=0", out_valid); end
  endtask

  task automatic test_signed_tie();
    logic signed [SW-1:0] exp_s;
    logic signed [DW-1:0] vals [4];
    exp_s = -91;
    vals[0] = -5; vals[1] = 7; vals[2] = 7; vals[3] = -100;
    do_reset();
    for (int k = 0; k < 4; k++) send(vals[k], 1'b1);
    for (int k = 0; k < 10; k++) send('0, 1'b1);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL signed_valid got=%0b exp=1", out_valid); end
    total++; if (sum_out !== exp_s) begin bad++; $display("FAIL signed_sum got=%0h exp=%0h", sum_out, exp_s); end
    total++; if (max_idx !== IW'(1)) begin bad++; $display("FAIL signed_tie_idx got=%0d exp=1", max_idx); end
    idle(1'b1);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < N; k++) send(DW'(2), 1'b0);
    for (int k = 0; k < N; k++) send(DW'(3), 1'b0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%0b exp=1", out_valid); end
    total++; if (sum_out !== SW'(28)) begin bad++; $display("FAIL b2b_sum_first got=%0d exp=28", sum_out); end
    idle(1'b0);
    idle(1'b0);
    total++; if (sum_out !== SW'(28) || out_valid !== 1'b1) begin bad++; $display("FAIL b2b_hold got=%0d/%0b exp=28/1", sum_out, out_valid); end
    idle(1'b1);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_second_valid got=%0b exp=1", out_valid); end
    total++; if (sum_out !== SW'(42)) begin bad++; $display("FAIL b2b_sum_second got=%0d exp=42", sum_out); end
    idle(1'b1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%0b exp=0", out_valid); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL b2b_overflow got=%0b exp=0", overflow); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 0; k < 2*N + 1; k++) send(DW'($urandom_range(0, 1000)), 1'b0);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0b exp=1", overflow); end
    total++; if (fill_level !== '0) begin bad++; $display("FAIL ovf_fill got=%0d exp=0", fill_level); end
    total++; if (sum_out !== ref_sum(exp_q[0])) begin bad++; $display("FAIL ovf_sum got=%0d exp=%0d", sum_out, ref_sum(exp_q[0])); end
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%0b exp=0", overflow); end
    // A drop in the same cycle as clear_err must leave the flag set.
    step(1'b1, DW'(5), 1'b0, 1'b0, 1'b0, 1'b1);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set_wins got=%0b exp=1", overflow); end
    // Both banks full but the read bank releases: the sample is accepted.
    send(DW'(6), 1'b1);
    total++; if (fill_level !== IW'(1) || overflow !== 1'b1) begin bad++; $display("FAIL ovf_release_accept got=%0d/%0b exp=1/1", fill_level, overflow); end
    total++; if (sum_out !== ref_sum(exp_q[0])) begin bad++; $display("FAIL ovf_second_sum got=%0d exp=%0d", sum_out, ref_sum(exp_q[0])); end
  endtask

  task automatic test_restart();
    do_reset();
    step(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    total++; if (fill_level !== '0 || out_valid !== 1'b0) begin bad++; $display("FAIL restart_empty got=%0d/%0b exp=0/0", fill_level, out_valid); end
    for (int k = 0; k < 5; k++) send(DW'(9), 1'b1);
    total++; if (fill_level !== IW'(5)) begin bad++; $display("FAIL restart_fill_before got=%0d exp=5", fill_level); end
    step(1'b1, DW'(4), 1'b1, 1'b1, 1'b0, 1'b0);
    total++; if (fill_level !== IW'(1)) begin bad++; $display("FAIL restart_fill_after got=%0d exp=1", fill_level); end
    for (int k = 0; k < 13; k++) send(DW'(1), 1'b1);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL restart_valid got=%0b exp=1", out_valid); end
    total++; if (sum_out !== SW'(17)) begin bad++; $display("FAIL restart_sum got=%0d exp=17", sum_out); end
    total++; if (max_idx !== '0) begin bad++; $display("FAIL restart_max_idx got=%0d exp=0", max_idx); end
    idle(1'b1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL restart_single got=%0b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < N + 7; k++) send(DW'($urandom_range(0, 50)), 1'b0);
    total++; if (out_valid !== 1'b1 || fill_level !== IW'(7)) begin bad++; $display("FAIL mid_pre got=%0b/%0d exp=1/7", out_valid, fill_level); end
    do_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%0b exp=0", out_valid); end
    total++; if (fill_level !== '0) begin bad++; $display("FAIL mid_fill got=%0d exp=0", fill_level); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL mid_overflow got=%0b exp=0", overflow); end
    for (int k = 0; k < N; k++) send(DW'(1), 1'b1);
    total++; if (out_valid !== 1'b1 || sum_out !== SW'(14)) begin bad++; $display("FAIL mid_fresh got=%0b/%0d exp=1/14", out_valid, sum_out); end
    idle(1'b1);
  endtask

  task automatic test_random();
    logic          v, rdy, rs, clr;
    logic [DW-1:0] d;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      d   = ($urandom_range(0, 1) != 0) ? DW'($urandom) : DW'($urandom_range(0, 6)) - DW'(3);
      rdy = ((i / 60) % 2 != 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) != 0);
      rs  = ($urandom_range(0, 40) == 0);
      clr = ($urandom_range(0, 15) == 0);
      step(v, d, rdy, rs, 1'b0, clr);
      total++; if (out_valid !== (exp_q.size() != 0)) begin bad++; $display("FAIL rand_valid cyc=%0d got=%0b exp=%0b", i, out_valid, exp_q.size() != 0); end
      total++; if (fill_level !== IW'(part_q.size())) begin bad++; $display("FAIL rand_fill cyc=%0d got=%0d exp=%0d", i, fill_level, part_q.size()); end
      total++; if (overflow !== exp_ovf) begin bad++; $display("FAIL rand_overflow cyc=%0d got=%0b exp=%0b", i, overflow, exp_ovf); end
      if (exp_q.size() != 0) begin
        total++; if (sum_out !== ref_sum(exp_q[0])) begin bad++; $display("FAIL rand_sum cyc=%0d got=%0h exp=%0h", i, sum_out, ref_sum(exp_q[0])); end
        total++; if (max_idx !== ref_argmax(exp_q[0])) begin bad++; $display("FAIL rand_max_idx cyc=%0d got=%0d exp=%0d", i, max_idx, ref_argmax(exp_q[0])); end
        total++; if (frame_out !== exp_q[0]) begin bad++; $display("FAIL rand_frame cyc=%0d first_word got=%0h exp=%0h", i, frame_out[0 +: DW], exp_q[0][0 +: DW]); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; vinput = '0; vinput_tvalid = 1'b0; frame_restart = 1'b0;
    clear_err = 1'b0; out_ready = 1'b0; exp_ovf = 1'b0;
    test_reset();
    test_basic();
    test_signed_tie();
    test_back_to_back();
    test_overflow();
    test_restart();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vinput_frame_collector.md
Name: vinput_frame_collector

Overview:
Downstream consumer of the vinput stream produced by the backbone-to-vinput stage.
- Gathers each group of N consecutive vinput samples (one per J index) into a frame vector.
- Computes the frame's signed sum and the index of its maximum.
- Presents each complete frame to the next stage through a valid/ready handshake.
- Uses ping-pong double buffering: the upstream stream has no backpressure, so the next frame can fill while the previous one waits.

Parameters:
N, 14, samples per frame (equals the upstream J)
DATAWIDTH, 32, sample width; signed two's complement fixed point
SUM_WIDTH, DATAWIDTH+$clog2(N)+1, width of the frame sum
IDX_WIDTH, $clog2(N)+1, width of the index fields

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
vinput  in  DATAWIDTH  sample from the upstream stage
vinput_tvalid  in  1  sample qualifier; no ready is returned upstream
frame_restart  in  1  discards the partial frame in the write bank (driven by first_backbone)
clear_err  in  1  clears the overflow flag
frame_out  out  N*DATAWIDTH  sample k at [k*DATAWIDTH +: DATAWIDTH]
sum_out  out  SUM_WIDTH  signed sum of the frame
max_idx  out  IDX_WIDTH  index of the largest sample; the lowest index wins a tie
out_valid  out  1  frame available on the outputs
out_ready  in  1  downstream accepts the frame
fill_level  out  IDX_WIDTH  samples held in the partial write-bank frame
overflow  out  1  sticky: a sample was dropped

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high; all state is cleared on it.
- Reset values: all outputs 0; both banks empty; write bank wb=0, read bank rb=0, count cnt=0, running sum 0, running max index 0.
- Accepting a sample: vinput_tvalid with bank wb not full.
  - Store the sample at bank[wb][cnt].
  - Running sum += sign-extended sample.
  - If cnt==0 or sample > running max (signed compare): running max = sample, running max index = cnt.
  - cnt increments.
- Frame completion: on acceptance with cnt==N-1:
  - The bank's sum/max_idx registers take the final values, including this sample.
  - full[wb]=1, wb toggles, cnt=0, running sum and running max are reset.
  - out_valid rises on the next cycle. Latency from the last sample to out_valid is one cycle.
- Output side:
  - out_valid = full[rb]; frame_out/sum_out/max_idx come from bank rb.
  - Outputs hold stable while out_valid=1 and out_ready=0.
  - On out_valid && out_ready: full[rb]=0 and rb toggles on the next edge.
  - Back-to-back frames are delivered on consecutive cycles when both banks are full.
- Overflow: vinput_tvalid while full[wb]=1 (both banks full).
  - The sample is dropped and overflow is set. cnt, the running sum and the running max are unchanged.
  - Exception: if the same cycle releases bank wb (rb==wb and out_ready), the sample is accepted normally.
- frame_restart:
  - cnt=0, running sum and running max reset; full banks are untouched.
  - If vinput_tvalid is asserted in the same cycle, that sample is taken as index 0 of the new frame.
  - A restart with cnt==0 has no effect.
- clear_err: clears overflow. If an overflow occurs in the same cycle, overflow stays set (the set wins).
- fill_level = cnt.
- Arithmetic: no saturation. With the default SUM_WIDTH the sum cannot overflow for N samples.
- Reset mid-frame or mid-handshake: the partial frame and any pending frames are discarded and out_valid drops on the next cycle.

Decomposition:
- Shared package vinput_pkg:
  - constants N_DEFAULT=14 and DATAWIDTH_DEFAULT=32;
  - function clog2_plus1 for the index widths;
  - packed typedef frame_t for the N-sample vector.
- One natural sub-module, frame_stat_acc: running sum and running argmax with start/accept/restart inputs. It is instantiated once and its result is captured into the per-bank stat registers at completion.
- The top level holds the two banks, the wb/rb/full control and the overflow logic.

Test Plan:
- Basic frame: N=14, samples 1..14 with out_ready=1 → out_valid one cycle after the 14th sample; sum_out=105, max_idx=13, frame_out[0]=1, frame_out[13]=14.
- Signed and tie: samples -5,7,7,-100, then 10 zeros (N=14) → sum_out=-91, max_idx=1.
- Backpressure and double buffering: out_ready=0 while sending 2 frames (all 2s, then all 3s) → out_valid held, sum_out=28. Raise out_ready → frames delivered on consecutive cycles with sums 28 then 42; overflow stays 0.
- Overflow: out_ready=0 while sending 2 full frames plus 1 extra sample → overflow=1, fill_level=0. Pulse clear_err → overflow=0.
- Restart: send 5 samples of 9, then frame_restart together with a valid sample of 4, then 13 samples of 1 → single frame: sum_out=17, max_idx=0, fill_level=5 just before the restart.
- Reset mid-operation: assert rst after 7 samples with one frame pending → out_valid=0, fill_level=0, overflow=0 on the next cycle. A following fresh frame of all 1s → sum_out=14.
